sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller between two requesters: the instruction-fetch port (read-only) and the memory-stage port (read/write).
- Sits between the pipeline stages and the SRAM controller.
- Sequences each transfer, holds the controller inputs stable until completion, and drives a per-port freeze back to the requesting stage.
- Memory stage has fixed priority; a bounded starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4: consecutive memory-stage grants allowed while fetch is pending before fetch is forced. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mem_read_en  input  1  memory-stage load request
- mem_write_en  input  1  memory-stage store request
- mem_addr  input  32  memory-stage byte address
- mem_wdata  input  32  store data
- mem_rdata  output  32  load data
- mem_freeze  output  1  stall memory stage
- if_read_en  input  1  fetch request
- if_addr  input  32  fetch byte address
- if_rdata  output  32  fetched word
- if_freeze  output  1  stall fetch
- sc_read_en  output  1  to SRAM controller
- sc_write_en  output  1  to SRAM controller
- sc_addr  output  32  to SRAM controller
- sc_wdata  output  32  to SRAM controller
- sc_rdata  input  32  from SRAM controller
- sc_ready  input  1  from SRAM controller; high for the cycle the transfer completes

Behaviour:
- Clock and reset: clk is the single clock; rst is asynchronous, active-high.
- States:
  - IDLE: no enables, no pending requests.
  - MEM_BUSY: memory-stage transfer in progress.
  - IF_BUSY: fetch transfer in progress.
  - GAP: one cycle with controller enables low after every completion.
- Arbitration is evaluated in IDLE and GAP.
  - If mem request and (no if request or starve_cnt < STARVE_LIMIT) -> MEM_BUSY.
  - Else if if request -> IF_BUSY.
  - Else -> IDLE.
- Grant capture: on a grant, latch op, address and wdata into registers. sc_addr, sc_wdata, sc_read_en and sc_write_en are driven only from these registers.
  - MEM_BUSY: sc_write_en = latched write, sc_read_en = latched read.
  - IF_BUSY: sc_read_en = 1.
  - All other states: both enables 0.
- Store precedence: if mem_write_en and mem_read_en are both high, the transfer is a write.
- Completion: in a BUSY state with sc_ready=1, the transfer completes and the next state is GAP. Without sc_ready, the state holds indefinitely.
- Freeze, combinational:
  - mem_freeze = (mem_read_en | mem_write_en) & ~(state==MEM_BUSY & sc_ready).
  - if_freeze = if_read_en & ~(state==IF_BUSY & sc_ready).
  - The requester therefore advances on the completion edge.
- Read data:
  - In the completion cycle of a read, the granted port's rdata = sc_rdata, passed through.
  - Otherwise each rdata shows its own register, which captures sc_rdata on that port's read completion.
  - Store completions do not update mem_rdata.
- starve_cnt (4 bits):
  - Clears on any IF grant, and whenever if_read_en is low at arbitration.
  - Increments on each MEM grant made while if_read_en is high; saturates at STARVE_LIMIT.
- Minimum latency: request in cycle 0 (IDLE) -> enables high in cycle 1 -> if sc_ready in cycle 1, freeze low in cycle 1 -> GAP in cycle 2.
- A requester holding its enable after completion is seen as a new request at GAP arbitration.
- Reset values: state IDLE, sc_read_en=0, sc_write_en=0, sc_addr=0, sc_wdata=0, mem_rdata=0, if_rdata=0, starve_cnt=0. Freezes follow the combinational rule, i.e. high if the corresponding enable is high.
- Reset mid-transfer: the transfer is abandoned and enables drop immediately (asynchronously). The requester stays frozen and is re-arbitrated after reset deasserts.
- Requester inputs changing during a transfer are ignored, since the transfer uses latched values.

Optional Feature:
- SRAM_ARB_IF_BUF_EN: adds a one-entry fetch buffer holding the tag (address[31:2]), the data word and a valid bit.
  - The entry is filled on every IF completion.
  - The valid bit is cleared on reset and on any MEM write whose address[31:2] matches the tag.
- Hit: when in IDLE or GAP with if_read_en high and if_addr[31:2] matching a valid tag:
  - if_rdata = buffered word and if_freeze = 0 in that same cycle.
  - No IF grant is made, and starve_cnt is not cleared.
  - A simultaneous mem request is still granted.
- Without the macro there is no buffer, and every fetch goes to the SRAM controller.

Test Plan:
- Lone load, mem_addr=0x100, sc_ready 3 cycles after grant, sc_rdata=0xDEADBEEF -> sc_read_en high 3 cycles, sc_addr=0x100, mem_freeze drops in the completion cycle, mem_rdata=0xDEADBEEF, GAP has enables low.
- Simultaneous store (addr 0x20, data 0x12345678) and fetch (0x0) -> MEM granted first with sc_write_en=1 and sc_wdata=0x12345678, if_freeze held high; IF is granted after GAP.
- Continuous mem loads plus a pending fetch, STARVE_LIMIT=4 -> exactly 4 MEM grants, then an IF grant; starve_cnt returns to 0.
- mem_read_en and mem_write_en both high -> sc_write_en=1, sc_read_en=0; mem_rdata unchanged.
- rst pulsed while in IF_BUSY -> sc_read_en=0 immediately, state IDLE; after release, the fetch is re-granted and completes normally.
- With SRAM_ARB_IF_BUF_EN: fetch 0x40 completes, then a re-fetch of 0x40 -> same-cycle hit, no sc_read_en. After a store to 0x40, a re-fetch goes to the SRAM controller again.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM controller between the fetch port (read-only)
// and the memory-stage port (read/write). The memory stage has fixed priority and a
// saturating starvation counter forces a fetch grant after STARVE_LIMIT memory grants.
// Optional feature macro: SRAM_ARB_IF_BUF_EN adds a one-entry fetch buffer.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_freeze,
  input  logic        if_read_en,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_freeze,
  output logic        sc_read_en,
  output logic        sc_write_en,
  output logic [31:0] sc_addr,
  output logic [31:0] sc_wdata,
  input  logic [31:0] sc_rdata,
  input  logic        sc_ready
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StMemBusy, StIfBusy, StGap} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_rdata_q;
  logic [31:0] if_rdata_q;
  logic [3:0]  starve_cnt;

  logic        arb_state;
  logic        mem_req;
  logic        if_req;
  logic        if_hit;
  logic        grant_mem;
  logic        grant_if;
  logic [31:0] buf_data;

  assign arb_state = (state == StIdle) || (state == StGap);
  assign mem_req   = mem_read_en | mem_write_en;
  // A buffer hit satisfies the fetch locally, so it does not compete for the controller.
  assign if_req    = if_read_en & ~if_hit;
  assign grant_mem = arb_state & mem_req & (~if_req | (starve_cnt < Limit));
  assign grant_if  = arb_state & ~grant_mem & if_req;

`ifdef SRAM_ARB_IF_BUF_EN
  logic        buf_valid;
  logic [29:0] buf_tag;

  assign if_hit = arb_state & if_read_en & buf_valid & (if_addr[31:2] == buf_tag);

  // Fetch buffer: refilled on every fetch completion, dropped when a store hits its tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == StIfBusy && sc_ready) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_q[31:2];
      buf_data  <= sc_rdata;
    end else if (grant_mem && mem_write_en && (mem_addr[31:2] == buf_tag)) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign if_hit   = 1'b0;
  assign buf_data = '0;
`endif

  // Transfer sequencer: arbitrate in Idle/Gap, latch the winner, hold until sc_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      sc_read_en  <= 1'b0;
      sc_write_en <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
      starve_cnt  <= '0;
    end else begin
      case (state)
        StIdle, StGap: begin
          if (grant_mem) begin
            state       <= StMemBusy;
            // Store wins when both enables are high.
            sc_write_en <= mem_write_en;
            sc_read_en  <= mem_read_en & ~mem_write_en;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
          end else if (grant_if) begin
            state       <= StIfBusy;
            sc_read_en  <= 1'b1;
            sc_write_en <= 1'b0;
            addr_q      <= if_addr;
          end else begin
            state <= StIdle;
          end
          if (grant_if || !if_read_en) begin
            starve_cnt <= '0;
          end else if (grant_mem && starve_cnt < Limit) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        StMemBusy: begin
          if (sc_ready) begin
            state       <= StGap;
            sc_read_en  <= 1'b0;
            sc_write_en <= 1'b0;
            if (sc_read_en) mem_rdata_q <= sc_rdata;
          end
        end
        StIfBusy: begin
          if (sc_ready) begin
            state       <= StGap;
            sc_read_en  <= 1'b0;
            sc_write_en <= 1'b0;
            if_rdata_q  <= sc_rdata;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign sc_addr  = addr_q;
  assign sc_wdata = wdata_q;

  // Freezes release in the completion cycle so the requester advances on that edge.
  assign mem_freeze = mem_req & ~(state == StMemBusy && sc_ready);
  assign if_freeze  = if_read_en & ~(state == StIfBusy && sc_ready) & ~if_hit;

  assign mem_rdata = (state == StMemBusy && sc_ready && sc_read_en) ? sc_rdata : mem_rdata_q;
  assign if_rdata  = (state == StIfBusy && sc_ready) ? sc_rdata :
                     (if_hit ? buf_data : if_rdata_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: randomized requesters, a behavioural
// SRAM controller, and scoreboard queues popped by per-port completion monitors.
module tb_sram_port_arbiter;
  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_freeze;
  logic        if_read_en = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_freeze;
  logic        sc_read_en, sc_write_en;
  logic [31:0] sc_addr, sc_wdata;
  logic [31:0] sc_rdata = '0;
  logic        sc_ready = 1'b0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_freeze(mem_freeze),
    .if_read_en(if_read_en), .if_addr(if_addr), .if_rdata(if_rdata), .if_freeze(if_freeze),
    .sc_read_en(sc_read_en), .sc_write_en(sc_write_en), .sc_addr(sc_addr),
    .sc_wdata(sc_wdata), .sc_rdata(sc_rdata), .sc_ready(sc_ready)
  );

  typedef struct {bit is_read; logic [31:0] data;} exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        mem_q[$];
  logic [31:0] if_q[$];
  int          grant_log[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sram [logic [31:0]];
  int          fixed_lat = -1;
  int          lat_left = 0;
  bit          sram_busy = 0;
  logic [31:0] last_load = '0;
  int          exp_seq [7] = '{1, 1, 1, 1, 2, 1, 1};

  // Reference arbitration state.
  int          exp_kind = 3;  // 0 none, 1 mem, 2 fetch, 3 no arbitration last cycle
  bit          exp_w, exp_r;
  logic [31:0] exp_addr, exp_wdata;
  int          cur_kind = 0;
  logic [31:0] cur_addr = '0;
  int          model_cnt = 0;
  bit          prev_done = 0;
  bit          buf_v = 0;
  logic [29:0] buf_tag = '0;
  bit          hit, mreq, ireq;
  int          n_en;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mem_issue(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d);
    exp_t e;
    mem_write_en = wr;
    mem_read_en  = rd;
    mem_addr     = a;
    mem_wdata    = d;
    if (wr) begin
      ref_mem[a] = d;
      e.is_read  = 1'b0;
      e.data     = '0;
    end else begin
      e.is_read = 1'b1;
      e.data    = ref_rd(a);
    end
    mem_q.push_back(e);
  endtask

  task automatic mem_finish();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!rst && !mem_freeze) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL mem_timeout: got no completion expected one within 200 cycles");
    end
    @(posedge clk); #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic if_issue(input logic [31:0] a);
    if_read_en = 1'b1;
    if_addr    = a;
    if_q.push_back(ref_rd(a));
  endtask

  task automatic if_finish();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!rst && !if_freeze) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL if_timeout: got no completion expected one within 200 cycles");
    end
    @(posedge clk); #1;
    if_read_en = 1'b0;
  endtask

  // SRAM controller model: random or fixed wait states, memory updated on store completion.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      sram_busy = 0;
      sc_ready  = 1'b0;
    end else begin
      #1;
      if (sc_read_en || sc_write_en) begin
        if (!sram_busy) begin
          sram_busy = 1;
          lat_left  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else if (lat_left > 0) begin
          lat_left--;
        end
        sc_ready = (lat_left == 0);
        if (sc_ready && sc_write_en) sram[sc_addr] = sc_wdata;
        sc_rdata = sc_ready ? sram_rd(sc_addr) : $urandom;
      end else begin
        sram_busy = 0;
        sc_ready  = 1'b0;
        sc_rdata  = $urandom;
      end
    end
  end

  // Memory-port monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      last_load = '0;
    end else if ((mem_read_en || mem_write_en) && !mem_freeze) begin
      if (mem_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_unexpected: got completion expected none");
      end else begin
        e = mem_q.pop_front();
        if (e.is_read) begin
          check("mem_rdata_load", mem_rdata, e.data);
          last_load = e.data;
        end else begin
          check("mem_rdata_store_hold", mem_rdata, last_load);
        end
      end
    end
  end

  // Fetch-port monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && if_read_en && !if_freeze) begin
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_unexpected: got completion expected none");
      end else begin
        check("if_rdata", if_rdata, if_q.pop_front());
      end
    end
  end

  // Controller-side checker: reference arbitration, latched outputs, one-cycle gap.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_cnt = 0; exp_kind = 3; prev_done = 0; buf_v = 0; cur_kind = 0;
    end else begin
      if (exp_kind == 1) begin
        check("grant_mem_we", sc_write_en, exp_w);
        check("grant_mem_re", sc_read_en, exp_r);
        check("grant_mem_addr", sc_addr, exp_addr);
        if (exp_w) check("grant_mem_wdata", sc_wdata, exp_wdata);
        grant_log.push_back(1);
        cur_kind = 1; cur_addr = exp_addr;
      end else if (exp_kind == 2) begin
        check("grant_if_en", {sc_read_en, sc_write_en}, 32'h2);
        check("grant_if_addr", sc_addr, exp_addr);
        grant_log.push_back(2);
        cur_kind = 2; cur_addr = exp_addr;
      end else if (exp_kind == 0) begin
        check("no_grant_en", {sc_read_en, sc_write_en}, 32'h0);
      end else if (sc_read_en || sc_write_en) begin
        check("hold_addr", sc_addr, cur_addr);
      end
      if (prev_done) check("gap_en_low", {sc_read_en, sc_write_en}, 32'h0);
`ifdef SRAM_ARB_IF_BUF_EN
      if ((sc_read_en || sc_write_en) && sc_ready && cur_kind == 2) begin
        buf_v = 1; buf_tag = cur_addr[31:2];
      end
`endif
      prev_done = (sc_read_en || sc_write_en) && sc_ready;
      if (!(sc_read_en || sc_write_en)) begin
        hit = 0;
`ifdef SRAM_ARB_IF_BUF_EN
        hit = buf_v && if_read_en && (if_addr[31:2] == buf_tag);
`endif
        mreq = mem_read_en || mem_write_en;
        ireq = if_read_en && !hit;
        if (mreq && (!ireq || model_cnt < Limit)) begin
          exp_kind  = 1;
          exp_w     = mem_write_en;
          exp_r     = mem_read_en && !mem_write_en;
          exp_addr  = mem_addr;
          exp_wdata = mem_wdata;
          if (if_read_en && model_cnt < Limit) model_cnt++;
`ifdef SRAM_ARB_IF_BUF_EN
          if (mem_write_en && mem_addr[31:2] == buf_tag) buf_v = 0;
`endif
        end else if (ireq) begin
          exp_kind  = 2;
          exp_addr  = if_addr;
          model_cnt = 0;
        end else begin
          exp_kind = 0;
        end
        if (!if_read_en) model_cnt = 0;
      end else begin
        exp_kind = 3;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected one before 500000");
    $fatal(1);
  end

  initial begin
    // Reset values; fetch enable high so its freeze must follow.
    if_read_en = 1'b1;
    #12;
    check("rst_sc_en", {sc_read_en, sc_write_en}, 32'h0);
    check("rst_sc_addr", sc_addr, 32'h0);
    check("rst_sc_wdata", sc_wdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_if_freeze", if_freeze, 32'h1);
    check("rst_mem_freeze", mem_freeze, 32'h0);
    if_read_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Lone load with three controller cycles.
    sram[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    fixed_lat = 2;
    n_en = 0;
    mem_issue(1'b0, 1'b1, 32'h100, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sc_read_en) begin
        n_en++;
        check("load_addr", sc_addr, 32'h100);
      end
      if (!mem_freeze) break;
    end
    check("load_en_cycles", n_en, 3);
    check("load_data", mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    mem_read_en = 1'b0;
    @(negedge clk);
    check("load_gap_low", {sc_read_en, sc_write_en}, 32'h0);
    @(posedge clk); #1;

    // Both enables high: a store, load data untouched.
    fixed_lat = 0;
    mem_issue(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mem_freeze) break;
    end
    check("both_we", sc_write_en, 32'h1);
    check("both_re", sc_read_en, 32'h0);
    check("both_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    @(posedge clk); #1;

    // Simultaneous store and fetch: store first, fetch after the gap.
    fixed_lat = 1;
    grant_log.delete();
    mem_issue(1'b1, 1'b0, 32'h20, 32'h1234_5678);
    if_issue(32'h0);
    @(negedge clk);
    @(negedge clk);
    check("sim_we", sc_write_en, 32'h1);
    check("sim_wdata", sc_wdata, 32'h1234_5678);
    check("sim_if_frozen", if_freeze, 32'h1);
    fork
      mem_finish();
      if_finish();
    join
    check("sim_order0", grant_log[0], 1);
    check("sim_order1", grant_log[1], 2);
    @(posedge clk); #1;

    // Reset in the middle of a fetch.
    fixed_lat = 3;
    if_issue(32'h8);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy", sc_read_en, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_en_drop", {sc_read_en, sc_write_en}, 32'h0);
    check("rst_mid_frozen", if_freeze, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    if_finish();
    @(posedge clk); #1;

    // Starvation bound: continuous loads against one pending fetch.
    fixed_lat = 0;
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          mem_issue(1'b0, 1'b1, 32'h1000 + 32'(4 * k), 32'h0);
          mem_finish();
        end
      end
      begin
        if_issue(32'h10);
        if_finish();
      end
    join
    check("starve_len", grant_log.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < grant_log.size()) check("starve_seq", grant_log[k], exp_seq[k]);
    end
    @(posedge clk); #1;

`ifdef SRAM_ARB_IF_BUF_EN
    // Fetch buffer: hit after fill, miss after an overlapping store.
    fixed_lat = 0;
    if_issue(32'h40);
    if_finish();
    if_issue(32'h40);
    @(negedge clk);
    check("buf_hit_nofreeze", if_freeze, 32'h0);
    @(posedge clk); #1;
    if_read_en = 1'b0;
    @(negedge clk);
    check("buf_hit_no_sc", sc_read_en, 32'h0);
    @(posedge clk); #1;
    mem_issue(1'b1, 1'b0, 32'h40, 32'h0BAD_C0DE);
    mem_finish();
    if_issue(32'h40);
    @(negedge clk);
    check("buf_inval_freeze", if_freeze, 32'h1);
    if_finish();
    @(posedge clk); #1;
`endif

    // Randomized concurrent traffic on disjoint address regions.
    fixed_lat = -1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          int op;
          op = int'($urandom_range(0, 2));
          mem_issue(op != 0, op != 1, 32'h1000 + 32'(4 * $urandom_range(0, 7)), $urandom);
          mem_finish();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int j = 0; j < 80; j++) begin
          if_issue(32'(4 * $urandom_range(0, 15)));
          if_finish();
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (3) @(posedge clk);
    check("mem_q_drained", mem_q.size(), 0);
    check("if_q_drained", if_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
